// File: rtl/serial_mag_comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM state encoding
// and the default operand width.
package serial_mag_comparator_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_mag_comparator_bcs_slice.sv
// One bit-cascade step of an MSB-first magnitude compare: "still equal" (e) and
// "already greater" (g) are refined by the next bit pair.
module bcs_slice (
    input  logic a_i,
    input  logic b_i,
    input  logic e_in,
    input  logic g_in,
    output logic e_out,
    output logic g_out
);

    // A greater bit only counts while every higher bit pair has matched.
    assign g_out = g_in | (e_in & a_i & ~b_i);
    assign e_out = e_in & ~(a_i ^ b_i);

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned comparator: one bit pair per cycle, MSB first, fixed
// WIDTH-cycle run followed by a one-cycle done pulse with registered gt/eq/lt.
module serial_mag_comparator
    import serial_mag_comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               e_q, e_d;
    logic               g_q, g_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               gt_q, gt_d;
    logic               eq_q, eq_d;
    logic               lt_q, lt_d;
    logic               e_out, g_out;

    bcs_slice u_slice (
        .a_i   (a_sh_q[WIDTH-1]),
        .b_i   (b_sh_q[WIDTH-1]),
        .e_in  (e_q),
        .g_in  (g_q),
        .e_out (e_out),
        .g_out (g_out)
    );

    always_comb begin
        // NOTE: every variable gets a hold-value default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        g_d     = g_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    e_d     = 1'b1;
                    g_d     = 1'b0;
                    cnt_d   = CNT_INIT;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q << 1;
                e_d    = e_out;
                g_d    = g_out;
                // No early exit: the run always covers all WIDTH bits for fixed latency.
                if (cnt_q == '0) begin
                    state_d = DONE;
                    gt_d    = g_out;
                    eq_d    = e_out;
                    lt_d    = ~g_out & ~e_out;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            g_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            g_q     <= g_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench for serial_mag_comparator (WIDTH=8): expected {gt,eq,lt} pushed
// at start, popped and compared when done pulses.
module tb_serial_mag_comparator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy, done, gt, eq, lt;

    int         n_pass = 0;
    int         n_total = 0;
    logic [2:0] exp_q[$];

    serial_mag_comparator #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model(input logic [7:0] x, input logic [7:0] y);
        return {x > y, x == y, x < y};
    endfunction

    // Called just after a negedge; returns at the negedge of the cycle after the start edge.
    task automatic push_start(input logic [7:0] x, input logic [7:0] y);
        a = x;
        b = y;
        start = 1'b1;
        exp_q.push_back(model(x, y));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pop_exp(output logic [2:0] e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 3'bxxx;
    endtask

    // Waits (bounded) for done; lat counts cycles after the start edge, the first being 1.
    task automatic collect(output int lat, output int bc, output logic chg, output logic [2:0] res);
        logic [2:0] snap;
        snap = {gt, eq, lt};
        lat = 0;
        bc = 0;
        chg = 1'b0;
        forever begin
            lat++;
            if (busy) bc++;
            if (done) break;
            if ({gt, eq, lt} !== snap) chg = 1'b1;
            if (lat >= 40) break;
            @(negedge clk);
        end
        res = {gt, eq, lt};
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({busy, done, gt, eq, lt} !== 5'b0)
            $display("FAIL reset_outputs: got %b expected %b", {busy, done, gt, eq, lt}, 5'b0);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_equal();
        int lat, bc;
        logic chg;
        logic [2:0] res, e;
        push_start(8'hA5, 8'hA5);
        collect(lat, bc, chg, res);
        pop_exp(e);
        n_total++;
        if (lat !== 9) $display("FAIL eq_latency: got %0d expected 9", lat); else n_pass++;
        n_total++;
        if (bc !== 8) $display("FAIL eq_busy_cycles: got %0d expected 8", bc); else n_pass++;
        n_total++;
        if (res !== e) $display("FAIL eq_result: got %b expected %b", res, e); else n_pass++;
        @(negedge clk);
        n_total++;
        if ({busy, done} !== 2'b00) $display("FAIL eq_done_one_cycle: got %b expected 00", {busy, done});
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if ({gt, eq, lt} !== e) $display("FAIL eq_hold_idle: got %b expected %b", {gt, eq, lt}, e);
        else n_pass++;
    endtask

    task automatic test_msb_lsb();
        logic [7:0] xs[2] = '{8'h80, 8'hFF};
        logic [7:0] ys[2] = '{8'h7F, 8'hFE};
        for (int i = 0; i < 2; i++) begin
            int lat, bc;
            logic chg;
            logic [2:0] res, e;
            repeat (2) @(negedge clk);
            push_start(xs[i], ys[i]);
            collect(lat, bc, chg, res);
            pop_exp(e);
            n_total++;
            if (lat !== 9) $display("FAIL gt_latency_%0d: got %0d expected 9", i, lat); else n_pass++;
            n_total++;
            if (res !== e) $display("FAIL gt_result_%0d: got %b expected %b", i, res, e); else n_pass++;
        end
    endtask

    task automatic test_operand_change();
        int lat, bc;
        logic chg;
        logic [2:0] res, e;
        repeat (2) @(negedge clk);
        push_start(8'h00, 8'hFF);
        a = 8'hFF;
        b = 8'h00;
        collect(lat, bc, chg, res);
        pop_exp(e);
        n_total++;
        if (res !== e) $display("FAIL opchg_result: got %b expected %b", res, e); else n_pass++;
        n_total++;
        if (chg !== 1'b0) $display("FAIL opchg_outputs_stable_in_run: got %b expected 0", chg); else n_pass++;
        n_total++;
        if (lat !== 9) $display("FAIL opchg_latency: got %0d expected 9", lat); else n_pass++;
    endtask

    task automatic test_ignored_start();
        int ndone = 0, done_cyc = 0, bc = 0;
        logic [2:0] res = 3'b000, e;
        repeat (2) @(negedge clk);
        push_start(8'h12, 8'h34);
        for (int c = 1; c <= 20; c++) begin
            if (busy) bc++;
            if (done) begin
                ndone++;
                done_cyc = c;
                res = {gt, eq, lt};
            end
            if (c == 3 || c == 8 || c == 9) begin
                a = 8'hFF;
                b = 8'h00;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        pop_exp(e);
        n_total++;
        if (ndone !== 1) $display("FAIL ign_done_count: got %0d expected 1", ndone); else n_pass++;
        n_total++;
        if (done_cyc !== 9) $display("FAIL ign_done_cycle: got %0d expected 9", done_cyc); else n_pass++;
        n_total++;
        if (res !== e) $display("FAIL ign_result: got %b expected %b", res, e); else n_pass++;
        n_total++;
        if (bc !== 8) $display("FAIL ign_busy_cycles: got %0d expected 8", bc); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        logic chg;
        logic [2:0] res, e, dropped;
        int seen_done = 0;
        repeat (2) @(negedge clk);
        push_start(8'h55, 8'h66);
        repeat (3) @(negedge clk);
        n_total++;
        if (busy !== 1'b1) $display("FAIL rst_busy_before: got %b expected 1", busy); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({busy, done, gt, eq, lt} !== 5'b0)
            $display("FAIL rst_async_clear: got %b expected %b", {busy, done, gt, eq, lt}, 5'b0);
        else n_pass++;
        dropped = exp_q.pop_back();
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        n_total++;
        if (seen_done !== 0) $display("FAIL rst_no_done: got %0d expected 0", seen_done); else n_pass++;
        push_start(8'h10, 8'h20);
        collect(lat, bc, chg, res);
        pop_exp(e);
        n_total++;
        if (lat !== 9) $display("FAIL rst_after_latency: got %0d expected 9", lat); else n_pass++;
        n_total++;
        if (res !== e) $display("FAIL rst_after_result: got %b expected %b (dropped %b)", res, e, dropped);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ndone = 0, last = 0, eq_bad = 0;
        logic [2:0] e;
        repeat (2) @(negedge clk);
        a = 8'h33;
        b = 8'h33;
        start = 1'b1;
        repeat (4) exp_q.push_back(model(8'h33, 8'h33));
        @(negedge clk);
        for (int c = 1; c <= 45; c++) begin
            if (done) begin
                ndone++;
                pop_exp(e);
                n_total++;
                if ({gt, eq, lt} !== e) $display("FAIL b2b_result_%0d: got %b expected %b", ndone, {gt, eq, lt}, e);
                else n_pass++;
                n_total++;
                if (c - last !== ((ndone == 1) ? 9 : 10))
                    $display("FAIL b2b_interval_%0d: got %0d expected %0d", ndone, c - last, (ndone == 1) ? 9 : 10);
                else n_pass++;
                last = c;
            end
            if (c >= 9 && eq !== 1'b1) eq_bad++;
            if (c == 39) start = 1'b0;
            @(negedge clk);
        end
        n_total++;
        if (ndone !== 4) $display("FAIL b2b_done_count: got %0d expected 4", ndone); else n_pass++;
        n_total++;
        if (eq_bad !== 0) $display("FAIL b2b_eq_held: got %0d bad cycles expected 0", eq_bad); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL b2b_idle_after: got %b expected 0", busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_equal();
        test_msb_lsb();
        test_operand_change();
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
